// File: rtl/sll_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sll_pkg : shared types and constants for the multicycle left shifter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sll_pkg;

  localparam int SLL_WIDTH  = 32;
  localparam int SLL_STAGES = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } sll_state_e;

endpackage
`default_nettype wire

// File: rtl/sll_multicycle_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sll_multicycle_if : start/ready handshake bundle for the shifter     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sll_multicycle_if;
  import sll_pkg::*;

  logic                 ctrl_shift;
  logic [SLL_WIDTH-1:0] data_operandA;
  logic [4:0]           ctrl_shiftamt;
  logic [SLL_WIDTH-1:0] data_result;
  logic                 data_resultRDY;
  logic                 data_exception;
  logic                 busy;

  modport master (
    output ctrl_shift, data_operandA, ctrl_shiftamt,
    input  data_result, data_resultRDY, data_exception, busy
  );

  modport slave (
    input  ctrl_shift, data_operandA, ctrl_shiftamt,
    output data_result, data_resultRDY, data_exception, busy
  );
endinterface
`default_nettype wire

// File: rtl/sll_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sll_step : one stage of the left shift, selected by stage index      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sll_step
  import sll_pkg::*;
(
  input  wire logic [SLL_WIDTH-1:0] acc_in,
  input  wire logic [2:0]           step,
  input  wire logic                 enable,
  output logic      [SLL_WIDTH-1:0] acc_out,
  output logic                      shifted_out
);

  // Stage index k selects a fixed shift by 2**k; shifted_out flags lost 1s.
  always_comb begin
    acc_out     = acc_in;
    shifted_out = 1'b0;
    if (enable) begin
      case (step)
        3'd4: begin
          acc_out     = {acc_in[15:0], 16'h0000};
          shifted_out = |acc_in[31:16];
        end
        3'd3: begin
          acc_out     = {acc_in[23:0], 8'h00};
          shifted_out = |acc_in[31:24];
        end
        3'd2: begin
          acc_out     = {acc_in[27:0], 4'h0};
          shifted_out = |acc_in[31:28];
        end
        3'd1: begin
          acc_out     = {acc_in[29:0], 2'b00};
          shifted_out = |acc_in[31:30];
        end
        3'd0: begin
          acc_out     = {acc_in[30:0], 1'b0};
          shifted_out = acc_in[31];
        end
        default: begin
          acc_out     = acc_in;
          shifted_out = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sll_multicycle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sll_multicycle : 32-bit logical left shift, one amount bit per clock |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sll_multicycle
  import sll_pkg::*;
(
  input  wire logic         clock,
  input  wire logic         reset,
  sll_multicycle_if.slave   bus
);

  sll_state_e           state;
  logic [SLL_WIDTH-1:0] acc;
  logic [4:0]           amt;
  logic [2:0]           step;
  logic                 lost;
  logic                 rdy;
  logic                 busy_q;

  logic [SLL_WIDTH-1:0] step_acc;
  logic                 step_out;

  sll_step u_step (
    .acc_in      (acc),
    .step        (step),
    .enable      (amt[step]),
    .acc_out     (step_acc),
    .shifted_out (step_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      acc    <= '0;
      amt    <= '0;
      step   <= '0;
      lost   <= 1'b0;
      rdy    <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          rdy <= 1'b0;
          if (bus.ctrl_shift) begin
            acc    <= bus.data_operandA;
            amt    <= bus.ctrl_shiftamt;
            step   <= 3'(SLL_STAGES - 1);
            lost   <= 1'b0;
            busy_q <= 1'b1;
            state  <= S_SHIFT;
          end else begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_SHIFT: begin
          acc  <= step_acc;
          lost <= lost | step_out;
          // Last stage: flag completion in the same edge that enters DONE.
          if (step == 3'd0) begin
            rdy    <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_DONE;
          end else begin
            step <= step - 3'd1;
          end
        end
        default: begin
          rdy    <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.data_result    = acc;
  assign bus.data_exception = lost;
  assign bus.data_resultRDY = rdy;
  assign bus.busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sll_multicycle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sll_multicycle : directed self-checking bench for sll_multicycle  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sll_multicycle;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  sll_multicycle_if bus ();

  sll_multicycle dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [4:0] amt);
    bus.ctrl_shift    = 1'b1;
    bus.data_operandA = a;
    bus.ctrl_shiftamt = amt;
    tick();
    bus.ctrl_shift    = 1'b0;
    bus.data_operandA = 32'hDEAD_BEEF;
    bus.ctrl_shiftamt = 5'd0;
  endtask

  // Five SHIFT cycles; optionally fire a junk start in cycle inj.
  task automatic run_shift(input string tag, input int inj);
    for (int i = 0; i < 5; i++) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_rdy_low"}, 32'(bus.data_resultRDY), 32'd0);
      if (i == inj) begin
        bus.ctrl_shift    = 1'b1;
        bus.data_operandA = 32'hFFFF_FFFF;
        bus.ctrl_shiftamt = 5'd16;
      end
      tick();
      bus.ctrl_shift = 1'b0;
    end
  endtask

  task automatic check_done(input string tag, input logic [31:0] res, input logic exc);
    chk({tag, "_rdy"}, 32'(bus.data_resultRDY), 32'd1);
    chk({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
    chk({tag, "_result"}, bus.data_result, res);
    chk({tag, "_exc"}, 32'(bus.data_exception), 32'(exc));
  endtask

  task automatic check_idle(input string tag, input logic [31:0] res, input logic exc);
    chk({tag, "_rdy_idle"}, 32'(bus.data_resultRDY), 32'd0);
    chk({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, "_held_result"}, bus.data_result, res);
    chk({tag, "_held_exc"}, 32'(bus.data_exception), 32'(exc));
  endtask

  initial begin
    bus.ctrl_shift    = 1'b0;
    bus.data_operandA = 32'h0;
    bus.ctrl_shiftamt = 5'd0;

    tick();
    tick();
    check_idle("reset", 32'h0, 1'b0);
    rst = 1'b0;
    tick();
    check_idle("post_reset", 32'h0, 1'b0);

    start_op(32'h0000_0001, 5'd31);
    run_shift("t1", -1);
    check_done("t1", 32'h8000_0000, 1'b0);
    tick();
    check_idle("t1", 32'h8000_0000, 1'b0);

    start_op(32'hF000_000F, 5'd4);
    run_shift("t2", -1);
    check_done("t2", 32'h0000_00F0, 1'b1);
    tick();
    check_idle("t2", 32'h0000_00F0, 1'b1);

    start_op(32'h1234_5678, 5'd0);
    run_shift("t3", -1);
    check_done("t3", 32'h1234_5678, 1'b0);
    tick();

    start_op(32'h8000_0001, 5'd1);
    run_shift("t4", -1);
    check_done("t4", 32'h0000_0002, 1'b1);
    tick();

    // Back-to-back: second start issued in the DONE cycle of the first.
    start_op(32'h0000_0001, 5'd1);
    run_shift("b2b_a", -1);
    check_done("b2b_a", 32'h0000_0002, 1'b0);
    start_op(32'h0000_0003, 5'd8);
    run_shift("b2b_b", -1);
    check_done("b2b_b", 32'h0000_0300, 1'b0);
    tick();
    check_idle("b2b", 32'h0000_0300, 1'b0);

    start_op(32'h0000_0001, 5'd3);
    run_shift("ign", 2);
    check_done("ign", 32'h0000_0008, 1'b0);
    tick();
    check_idle("ign", 32'h0000_0008, 1'b0);
    tick();
    check_idle("ign2", 32'h0000_0008, 1'b0);

    // Abort two cycles into SHIFT.
    start_op(32'h0000_AAAA, 5'd5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("abort", 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_idle("abort_wait", 32'h0, 1'b0);
    end

    // Reset and start together: start is lost.
    rst = 1'b1;
    start_op(32'h0000_0005, 5'd2);
    rst = 1'b0;
    check_idle("rst_vs_start", 32'h0, 1'b0);
    tick();
    check_idle("rst_vs_start2", 32'h0, 1'b0);

    start_op(32'h0000_00FF, 5'd28);
    run_shift("fresh", -1);
    check_done("fresh", 32'hF000_0000, 1'b1);
    tick();
    check_idle("fresh", 32'hF000_0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sll_multicycle.md
# sll_multicycle

Multicycle 32-bit logical left shifter for the processor ALU path, the left-direction counterpart of the single-cycle arithmetic right barrel shifter. It resolves one shift-amount bit per clock (16, 8, 4, 2, 1), MSB first, behind a start/ready handshake, and reports whether any 1 bit was shifted out. The pipeline stall logic uses it when a long shift must leave the single-cycle ALU.

## Interface
- No parameters; width fixed at 32 bits, shift amount at 5 bits.
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the rising edge where sampled high
- ctrl_shift  in  1  start request; sampled only in IDLE or DONE
- data_operandA  in  32  value to shift; captured with ctrl_shift
- ctrl_shiftamt  in  5  shift amount 0–31; captured with ctrl_shift
- data_result  out  32  shifted value; held stable from DONE until the next accepted start
- data_resultRDY  out  1  one-cycle pulse; data_result and data_exception valid
- data_exception  out  1  1 if any 1 bit was shifted past bit 31
- busy  out  1  high in SHIFT state

## Operation
- Registers:
  - acc[31:0]: working value.
  - amt[4:0]: captured shift amount.
  - step[2:0]: stage index, counts 4 down to 0.
  - lost: sticky OR of the bits shifted out.
- States:
  - IDLE: ctrl_shift=1 → acc←data_operandA, amt←ctrl_shiftamt, step←4, lost←0, go to SHIFT.
  - SHIFT: if amt[step]=1, acc←acc<<(1<<step) and lost←lost | (OR of the top (1<<step) bits of acc). Otherwise acc and lost are unchanged. If step=0, go to DONE; else step←step−1.
  - DONE: data_resultRDY=1. If ctrl_shift=1, capture as in IDLE and go to SHIFT (back-to-back). Otherwise go to IDLE.
- Outputs:
  - data_result = acc; data_exception = lost.
  - Both are meaningful only when data_resultRDY=1, and are held afterwards until the next capture.
- Zeros always fill from the LSB. There is no sign handling.
- Shift amount 0 still runs all five SHIFT cycles and yields result = A, exception = 0.
- ctrl_shift during SHIFT is ignored: no queuing and no error. Operands present in that cycle are dropped.
- Reset values: state=IDLE, acc=0, amt=0, step=0, lost=0. So data_result=0, data_resultRDY=0, data_exception=0, busy=0.
- Reset asserted in any state, including mid-SHIFT, aborts the operation. No data_resultRDY pulse follows.
- Simultaneous reset and ctrl_shift: reset wins and the start is lost.

## Timing
- Start sampled at edge N.
- SHIFT occupies the cycles after edges N through N+4, processing stages 16, 8, 4, 2, 1 in order.
- Edge N+5 enters DONE. data_resultRDY is high for exactly the cycle between edges N+5 and N+6.
- Fixed latency: 5 edges from the start edge to RDY; the result is visible in the 6th cycle counting the start cycle.
- busy is high for the 5 SHIFT cycles. It is low in the DONE cycle.
- Back-to-back: a start in the DONE cycle is accepted at edge N+5. The next RDY appears 5 edges later, giving a sustained throughput of one result per 5 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package sll_pkg:
  - state encoding: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10; 2'b11 recovers to IDLE.
  - SLL_WIDTH=32, SLL_STAGES=5.
- Sub-module sll_step:
  - Combinational.
  - Inputs: acc, step, enable.
  - Outputs: next acc, and the OR of the bits shifted out.
  - Implemented as a 5-way select of fixed shifts by 16, 8, 4, 2 and 1.
- The top module holds the FSM, the counter and the registers.

## Test plan
- Reset, then start with A=32'h0000_0001, amt=31 → RDY after 5 edges; result=32'h8000_0000, exception=0, busy high for exactly 5 cycles.
- A=32'hF000_000F, amt=4 → result=32'h0000_00F0, exception=1.
- A=32'h1234_5678, amt=0 → full latency; result=32'h1234_5678, exception=0.
- Back-to-back: the first start (A=32'h1, amt=1) receives the second start (A=32'h3, amt=8) in its DONE cycle → RDY pulses 5 edges apart with results 32'h2, then 32'h300.
- Start during SHIFT (A=32'hFFFF_FFFF, amt=16) while the prior op A=32'h1, amt=3 is running → ignored; only result 32'h8 appears, then IDLE.
- Reset asserted 2 cycles into SHIFT → no RDY pulse; all outputs 0 next cycle; a fresh start completes normally.
